// File: rtl/color_zone_detector_pkg.sv
// ---------------------------------------------------------------------------
// color_det_pkg
// Shared types and helpers for the colour zone detector.
//   rgb565_t     : RGB565 pixel split into its colour fields
//   cfg_t        : threshold set sampled at every frame start
//   CFG_RESET    : threshold values loaded by reset
//   state_t      : frame FSM states
//   zone_centre  : centre coordinate of zone idx along one axis
//   sum_width    : bit width of a window sum that can never wrap
// ---------------------------------------------------------------------------
package color_det_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [4:0] r_min;
    logic [5:0] g_max;
    logic [4:0] b_max;
    logic [4:0] r_minus_g;
    logic [4:0] r_minus_b;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    r_min:     5'd10,
    g_max:     6'd32,
    b_max:     5'd16,
    r_minus_g: 5'd4,
    r_minus_b: 5'd4
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Zones split the axis into nzones equal slices; the centre of each slice
  // uses integer division so it matches a software reference exactly.
  function automatic int zone_centre(input int idx, input int extent, input int nzones);
    return ((2 * idx + 1) * extent) / (2 * nzones);
  endfunction

  // A window sum holds win*win samples of at most max_val each.
  function automatic int sum_width(input int win, input int max_val);
    return $clog2(win * win * max_val + 1);
  endfunction

endpackage

// File: rtl/color_zone_detector_zone_accum.sv
// ---------------------------------------------------------------------------
// zone_accum
// One detection window: counts the in-window pixels of the current frame,
// accumulates the R/G/B sums and, on the last window pixel, forms the
// pass/fail decision and holds it in a pending register.
//   pclk, rst_n   : pixel clock, asynchronous active-low reset
//   clear         : frame start, empties counters, sums and pending
//   pix_en        : pixel accepted this cycle at (pix_x, pix_y)
//   pix           : accepted pixel value
//   cfg           : thresholds that apply to this pixel
//   pending_next  : pending decision including this cycle's pixel
// ---------------------------------------------------------------------------
module zone_accum
  import color_det_pkg::*;
#(
  parameter int XW  = 9,
  parameter int YW  = 8,
  parameter int XC  = 0,
  parameter int YC  = 0,
  parameter int WIN = 5
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          pix_en,
  input  logic [XW-1:0] pix_x,
  input  logic [YW-1:0] pix_y,
  input  rgb565_t       pix,
  input  cfg_t          cfg,
  output logic          pending_next
);

  localparam int HALF = WIN / 2;
  localparam int N    = WIN * WIN;
  localparam int SWR  = sum_width(WIN, 31);
  localparam int SWG  = sum_width(WIN, 63);
  localparam int SWB  = sum_width(WIN, 31);
  localparam int CW   = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0]  count, count_n, base_cnt;
  logic [SWR-1:0] sum_r, base_r, add_r;
  logic [SWG-1:0] sum_g, base_g, add_g;
  logic [SWB-1:0] sum_b, base_b, add_b;
  logic           pending, base_pend;
  logic           in_win, take, decide, pass;
  logic signed [31:0] xs, ys;
  logic signed [31:0] tot_r, tot_g, tot_b, diff_rg, diff_rb;
  logic signed [31:0] thr_r, thr_g, thr_b, thr_rg, thr_rb;

  assign xs = 32'(pix_x);
  assign ys = 32'(pix_y);

  // Window membership is evaluated signed so that windows hanging over the
  // picture edge simply lose their off-picture part and never complete.
  assign in_win = (xs >= XC - HALF) && (xs <= XC + HALF) &&
                  (ys >= YC - HALF) && (ys <= YC + HALF);

  // A frame start empties the window first, so a pixel arriving in the same
  // cycle is accumulated into a fresh frame. Accumulation stops once the
  // window is full. The decision uses the sums including the final pixel
  // and all comparisons are done in 32-bit signed arithmetic.
  always_comb begin
    base_cnt  = clear ? '0   : count;
    base_r    = clear ? '0   : sum_r;
    base_g    = clear ? '0   : sum_g;
    base_b    = clear ? '0   : sum_b;
    base_pend = clear ? 1'b0 : pending;

    take   = pix_en && in_win && (base_cnt != CNT_FULL);
    decide = take && (base_cnt == CNT_LAST);

    add_r = base_r + SWR'(pix.r);
    add_g = base_g + SWG'(pix.g);
    add_b = base_b + SWB'(pix.b);

    tot_r   = 32'(add_r);
    tot_g   = 32'(add_g);
    tot_b   = 32'(add_b);
    diff_rg = tot_r - (tot_g >>> 1);
    diff_rb = tot_r - tot_b;

    thr_r  = N * 32'(cfg.r_min);
    thr_g  = N * 32'(cfg.g_max);
    thr_b  = N * 32'(cfg.b_max);
    thr_rg = N * 32'(cfg.r_minus_g);
    thr_rb = N * 32'(cfg.r_minus_b);

    pass = (tot_r >= thr_r) && (tot_g <= thr_g) && (tot_b <= thr_b) &&
           (diff_rg >= thr_rg) && (diff_rb >= thr_rb);

    count_n      = take   ? base_cnt + CW'(1) : base_cnt;
    pending_next = decide ? pass              : base_pend;
  end

  // Window state registers; reset leaves an empty window with no decision.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sum_r   <= '0;
      sum_g   <= '0;
      sum_b   <= '0;
      pending <= 1'b0;
    end else begin
      count   <= count_n;
      sum_r   <= take ? add_r : base_r;
      sum_g   <= take ? add_g : base_g;
      sum_b   <= take ? add_b : base_b;
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/color_zone_detector.sv
// ---------------------------------------------------------------------------
// color_zone_detector
// Splits each camera frame into NX x NY zones, averages a WIN x WIN window
// at the centre of every zone and reports which zones look red enough.
//   pclk, rst_n        : pixel clock, asynchronous active-low reset
//   frame_start        : one-cycle frame start pulse
//   pix_valid/pix_data : RGB565 pixels in raster order, gaps allowed
//   cfg_*              : thresholds, sampled at frame start
//   zone_hit           : per-zone result of the last completed frame
//   any_hit            : OR of zone_hit
//   result_valid       : one-cycle pulse when zone_hit updates
//   frame_err          : one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
module color_zone_detector
  import color_det_pkg::*;
#(
  parameter int W   = 320,
  parameter int H   = 240,
  parameter int NX  = 3,
  parameter int NY  = 3,
  parameter int WIN = 5
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [15:0]      pix_data,
  input  logic [4:0]       cfg_r_min,
  input  logic [5:0]       cfg_g_max,
  input  logic [4:0]       cfg_b_max,
  input  logic [4:0]       cfg_r_minus_g,
  input  logic [4:0]       cfg_r_minus_b,
  output logic [NX*NY-1:0] zone_hit,
  output logic             any_hit,
  output logic             result_valid,
  output logic             frame_err
);

  localparam int XW = $clog2(W + 1);
  localparam int YW = $clog2(H + 1);

  state_t           state;
  logic [XW-1:0]    x, cur_x, x_next;
  logic [YW-1:0]    y, cur_y, y_next;
  cfg_t             cfg_q, cfg_in, cfg_eff;
  rgb565_t          pix;
  logic             accept, x_wrap, last_pix;
  logic [NX*NY-1:0] pend_next;

  assign pix    = rgb565_t'(pix_data);
  assign cfg_in = '{
    r_min:     cfg_r_min,
    g_max:     cfg_g_max,
    b_max:     cfg_b_max,
    r_minus_g: cfg_r_minus_g,
    r_minus_b: cfg_r_minus_b
  };

  // A pixel that arrives together with frame_start is pixel (0,0) of the new
  // frame and is judged with the thresholds being sampled in that cycle.
  always_comb begin
    cur_x    = frame_start ? '0 : x;
    cur_y    = frame_start ? '0 : y;
    cfg_eff  = frame_start ? cfg_in : cfg_q;
    accept   = pix_valid && (frame_start || (state == ACTIVE));
    x_wrap   = (cur_x == XW'(W - 1));
    last_pix = accept && x_wrap && (cur_y == YW'(H - 1));
    x_next   = cur_x;
    y_next   = cur_y;
    if (accept) begin
      if (x_wrap) begin
        x_next = '0;
        y_next = cur_y + YW'(1);
      end else begin
        x_next = cur_x + XW'(1);
      end
    end
  end

  // One accumulator per zone; bit k of the result is row k/NX, column k%NX.
  for (genvar gy = 0; gy < NY; gy++) begin : g_row
    for (genvar gx = 0; gx < NX; gx++) begin : g_col
      zone_accum #(
        .XW  (XW),
        .YW  (YW),
        .XC  (zone_centre(gx, W, NX)),
        .YC  (zone_centre(gy, H, NY)),
        .WIN (WIN)
      ) u_zone (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .clear        (frame_start),
        .pix_en       (accept),
        .pix_x        (cur_x),
        .pix_y        (cur_y),
        .pix          (pix),
        .cfg          (cfg_eff),
        .pending_next (pend_next[gy*NX+gx])
      );
    end
  end

  // Frame FSM with registered outputs. The final pixel publishes every
  // pending decision at once; a frame_start in ACTIVE flags the aborted
  // frame but leaves the previously published result untouched.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      cfg_q        <= CFG_RESET;
      zone_hit     <= '0;
      any_hit      <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= last_pix;
      frame_err    <= frame_start && (state == ACTIVE);
      x            <= x_next;
      y            <= y_next;
      if (frame_start) begin
        cfg_q <= cfg_in;
      end
      if (last_pix) begin
        state    <= DONE;
        zone_hit <= pend_next;
        any_hit  <= |pend_next;
      end else if (frame_start) begin
        state <= ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_color_zone_detector.sv
// ---------------------------------------------------------------------------
// tb_color_zone_detector
// Directed bench for color_zone_detector. dut uses a 40x30 picture with the
// default 3x3 zones and 5x5 windows; dut2 uses a 32x16 picture with 4x2
// zones, 3x3 windows and random gaps in pix_valid.
// ---------------------------------------------------------------------------
module tb_color_zone_detector;

  localparam int W1 = 40;
  localparam int H1 = 30;
  localparam int FRAME = W1 * H1;

  localparam int PAT_RED   = 0;
  localparam int PAT_Z4    = 1;
  localparam int PAT_GREY  = 2;
  localparam int PAT_BLACK = 3;

  logic pclk = 1'b0;
  logic rst_n;

  logic        frame_start, pix_valid;
  logic [15:0] pix_data;
  logic [4:0]  cfg_r_min, cfg_b_max, cfg_r_minus_g, cfg_r_minus_b;
  logic [5:0]  cfg_g_max;
  logic [8:0]  zone_hit;
  logic        any_hit, result_valid, frame_err;

  logic        fs2, pv2;
  logic [15:0] pd2;
  logic [4:0]  c2_r_min, c2_b_max, c2_rmg, c2_rmb;
  logic [5:0]  c2_g_max;
  logic [7:0]  zone_hit2;
  logic        any_hit2, result_valid2, frame_err2;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  color_zone_detector #(.W(W1), .H(H1), .NX(3), .NY(3), .WIN(5)) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .cfg_r_min     (cfg_r_min),
    .cfg_g_max     (cfg_g_max),
    .cfg_b_max     (cfg_b_max),
    .cfg_r_minus_g (cfg_r_minus_g),
    .cfg_r_minus_b (cfg_r_minus_b),
    .zone_hit      (zone_hit),
    .any_hit       (any_hit),
    .result_valid  (result_valid),
    .frame_err     (frame_err)
  );

  color_zone_detector #(.W(32), .H(16), .NX(4), .NY(2), .WIN(3)) dut2 (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .frame_start   (fs2),
    .pix_valid     (pv2),
    .pix_data      (pd2),
    .cfg_r_min     (c2_r_min),
    .cfg_g_max     (c2_g_max),
    .cfg_b_max     (c2_b_max),
    .cfg_r_minus_g (c2_rmg),
    .cfg_r_minus_b (c2_rmb),
    .zone_hit      (zone_hit2),
    .any_hit       (any_hit2),
    .result_valid  (result_valid2),
    .frame_err     (frame_err2)
  );

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Default thresholds, or the relaxed set that lets a grey frame pass.
  task automatic setCfg(input bit relaxed);
    cfg_r_min     = 5'd10;
    cfg_g_max     = 6'd32;
    cfg_b_max     = 5'd16;
    cfg_r_minus_g = relaxed ? 5'd0 : 5'd4;
    cfg_r_minus_b = relaxed ? 5'd0 : 5'd4;
  endtask

  function automatic logic [15:0] pix1(input int pat, input int x, input int y);
    case (pat)
      PAT_RED:  return 16'hF800;
      PAT_Z4:   return (x >= 18 && x <= 22 && y >= 13 && y <= 17) ? 16'hF800 : 16'h0000;
      PAT_GREY: return 16'h8410;
      default:  return 16'h0000;
    endcase
  endfunction

  // start_mode: 0 = separate frame_start cycle, 1 = frame_start with first
  // pixel, 2 = no frame_start. cfg_change_at switches to relaxed thresholds
  // while that pixel is presented.
  task automatic applyStimulus(input int pat, input int start_mode, input int npix,
                               input int cfg_change_at);
    if (start_mode == 0) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    for (int i = 0; i < npix; i++) begin
      pix_valid   = 1'b1;
      pix_data    = pix1(pat, i % W1, i / W1);
      frame_start = (start_mode == 1) && (i == 0);
      if (i == cfg_change_at) setCfg(1'b1);
      tick();
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 16'h0000;
  endtask

  // Second picture: eight 8x8 regions with distinct base colours, R dithered
  // by one LSB on odd (x+y).
  function automatic logic [15:0] pix2(input int x, input int y);
    int k, r, g, b;
    k = x / 8 + 4 * (y / 8);
    case (k)
      0:       begin r = 31; g = 0;  b = 0;  end
      1:       begin r = 16; g = 32; b = 16; end
      2:       begin r = 20; g = 10; b = 3;  end
      3:       begin r = 8;  g = 0;  b = 0;  end
      4:       begin r = 31; g = 40; b = 0;  end
      5:       begin r = 31; g = 0;  b = 20; end
      6:       begin r = 12; g = 10; b = 9;  end
      default: begin r = 25; g = 20; b = 5;  end
    endcase
    r = r - ((x + y) % 2);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  // Reference: sum each 3x3 window directly from the picture and apply the
  // default thresholds scaled by N = 9.
  function automatic logic [7:0] model2();
    logic [7:0] hits;
    logic [15:0] p;
    hits = '0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) begin
        int xc, yc, sr, sg, sb;
        xc = ((2 * i + 1) * 32) / 8;
        yc = ((2 * j + 1) * 16) / 4;
        sr = 0; sg = 0; sb = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            p  = pix2(xc + dx, yc + dy);
            sr = sr + int'(p[15:11]);
            sg = sg + int'(p[10:5]);
            sb = sb + int'(p[4:0]);
          end
        end
        hits[j*4+i] = (sr >= 9 * 10) && (sg <= 9 * 32) && (sb <= 9 * 16) &&
                      (sr - sg / 2 >= 9 * 4) && (sr - sb >= 9 * 4);
      end
    end
    return hits;
  endfunction

  task automatic applyStimulus2();
    fs2 = 1'b1;
    tick();
    fs2 = 1'b0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 32; x++) begin
        while ($urandom_range(0, 3) == 0) begin
          pv2 = 1'b0;
          tick();
        end
        pv2 = 1'b1;
        pd2 = pix2(x, y);
        tick();
      end
    end
    pv2 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic rv_seen;
    rst_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
    fs2 = 1'b0; pv2 = 1'b0; pd2 = 16'h0000;
    c2_r_min = 5'd10; c2_g_max = 6'd32; c2_b_max = 5'd16; c2_rmg = 5'd4; c2_rmb = 5'd4;
    setCfg(1'b0);
    tick();
    tick();
    checkOutput("reset_zone_hit", 32'(zone_hit), 32'h0);
    checkOutput("reset_any_hit", 32'(any_hit), 32'h0);
    checkOutput("reset_result_valid", 32'(result_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_zone_hit2", 32'(zone_hit2), 32'h0);
    rst_n = 1'b1;
    tick();

    // Full red frame; nothing visible until the last pixel.
    applyStimulus(PAT_RED, 0, FRAME - 1, -1);
    checkOutput("red_early_valid", 32'(result_valid), 32'h0);
    checkOutput("red_early_hit", 32'(zone_hit), 32'h0);
    applyStimulus(PAT_RED, 2, 1, -1);
    checkOutput("red_valid", 32'(result_valid), 32'h1);
    checkOutput("red_zone_hit", 32'(zone_hit), 32'h1FF);
    checkOutput("red_any_hit", 32'(any_hit), 32'h1);
    checkOutput("red_frame_err", 32'(frame_err), 32'h0);
    tick();
    checkOutput("red_valid_pulse", 32'(result_valid), 32'h0);

    // Only zone 4 window is red; frame_start merged with the first pixel.
    applyStimulus(PAT_Z4, 1, FRAME, -1);
    checkOutput("z4_valid", 32'(result_valid), 32'h1);
    checkOutput("z4_zone_hit", 32'(zone_hit), 32'h010);

    // Grey fails on R-G/2; relaxing thresholds mid-frame must not help.
    applyStimulus(PAT_GREY, 0, FRAME, 500);
    checkOutput("grey_zone_hit", 32'(zone_hit), 32'h0);
    checkOutput("grey_any_hit", 32'(any_hit), 32'h0);
    applyStimulus(PAT_GREY, 0, FRAME, -1);
    checkOutput("grey_relaxed_hit", 32'(zone_hit), 32'h1FF);

    // Abort a red frame: result held, then a black frame reports nothing.
    setCfg(1'b0);
    applyStimulus(PAT_Z4, 0, FRAME, -1);
    checkOutput("z4b_zone_hit", 32'(zone_hit), 32'h010);
    applyStimulus(PAT_RED, 0, 1000, -1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("abort_frame_err", 32'(frame_err), 32'h1);
    checkOutput("abort_no_valid", 32'(result_valid), 32'h0);
    checkOutput("abort_hold_hit", 32'(zone_hit), 32'h010);
    tick();
    checkOutput("abort_err_pulse", 32'(frame_err), 32'h0);
    applyStimulus(PAT_BLACK, 2, FRAME, -1);
    checkOutput("after_abort_black", 32'(zone_hit), 32'h0);
    checkOutput("after_abort_valid", 32'(result_valid), 32'h1);

    applyStimulus(PAT_RED, 0, 1000, -1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("abort2_frame_err", 32'(frame_err), 32'h1);
    applyStimulus(PAT_RED, 2, FRAME, -1);
    checkOutput("after_abort_red", 32'(zone_hit), 32'h1FF);

    // Asynchronous reset in the middle of a frame.
    applyStimulus(PAT_RED, 0, 600, -1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_zone_hit", 32'(zone_hit), 32'h0);
    checkOutput("midreset_any_hit", 32'(any_hit), 32'h0);
    checkOutput("midreset_valid", 32'(result_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pixels in IDLE are ignored; the next frame restarts normally.
    applyStimulus(PAT_RED, 2, 5, -1);
    checkOutput("idle_ignore_valid", 32'(result_valid), 32'h0);
    applyStimulus(PAT_Z4, 1, FRAME, -1);
    checkOutput("post_reset_z4", 32'(zone_hit), 32'h010);

    // Pixels in DONE are ignored.
    rv_seen = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'hF800;
      tick();
      rv_seen = rv_seen | result_valid;
    end
    pix_valid = 1'b0;
    checkOutput("done_ignore_valid", 32'(rv_seen), 32'h0);
    checkOutput("done_ignore_hit", 32'(zone_hit), 32'h010);

    // Second instance with random pix_valid gaps against the model.
    applyStimulus2();
    checkOutput("gap_valid", 32'(result_valid2), 32'h1);
    checkOutput("gap_model", 32'(zone_hit2), 32'(model2()));
    checkOutput("gap_hand", 32'(zone_hit2), 32'h85);
    checkOutput("gap_any_hit", 32'(any_hit2), 32'h1);
    tick();
    checkOutput("gap_valid_pulse", 32'(result_valid2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_zone_detector.md
COLOR_ZONE_DETECTOR -- requirements
Module: color_zone_detector

Interface
REQ-001 Parameter W, default 320: active pixels per line.
REQ-002 Parameter H, default 240: active lines per frame.
REQ-003 Parameter NX, default 3: zone columns.
REQ-004 Parameter NY, default 3: zone rows. NZ = NX*NY.
REQ-005 Parameter WIN, default 5: odd window side in pixels, 1..15.
REQ-006 pclk  in  1: camera pixel clock, the only clock.
REQ-007 rst_n  in  1: reset, asynchronous, active-low.
REQ-008 frame_start  in  1: one-cycle pulse marking the start of a frame.
REQ-009 pix_valid  in  1: pix_data is valid this cycle.
REQ-010 pix_data  in  16: RGB565 pixel, R[15:11], G[10:5], B[4:0], raster order.
REQ-011 cfg_r_min  in  5: minimum average R.
REQ-012 cfg_g_max  in  6: maximum average G.
REQ-013 cfg_b_max  in  5: maximum average B.
REQ-014 cfg_r_minus_g  in  5: minimum of avgR - avgG/2.
REQ-015 cfg_r_minus_b  in  5: minimum of avgR - avgB.
REQ-016 zone_hit  out  NZ: per-zone result of the last completed frame; bit k = row (k/NX), column (k%NX).
REQ-017 any_hit  out  1: OR of zone_hit.
REQ-018 result_valid  out  1: one-cycle pulse when zone_hit updates.
REQ-019 frame_err  out  1: one-cycle pulse when a frame is aborted.

Function
REQ-020 Zone centres SHALL be Xc[i] = ((2i+1)*W)/(2*NX) and Yc[j] = ((2j+1)*H)/(2*NY), using integer division; a window covers |x-Xc| <= WIN/2 and |y-Yc| <= WIN/2.
REQ-021 The FSM SHALL have three states: IDLE, ACTIVE and DONE; frame_start from any state clears x, y, all sums and counts, samples all cfg_* inputs into registers, and enters ACTIVE.
REQ-022 In ACTIVE, each pix_valid cycle SHALL advance x from 0 to W-1, then wrap x to 0 and increment y; gaps in pix_valid are allowed.
REQ-023 When frame_start and pix_valid occur in the same cycle, the pixel SHALL count as (0,0) of the new frame.
REQ-024 Each zone SHALL accumulate sumR, sumG and sumB over exactly WIN*WIN in-window pixels; sum widths are clog2(WIN*WIN*max+1), with no wrap.
REQ-025 On a zone's WIN*WIN-th pixel, the zone SHALL form its decision from sums that include that pixel. The decision passes only if all of the following hold:
  - sumR >= N*r_min
  - sumG <= N*g_max
  - sumB <= N*b_max
  - sumR - floor(sumG/2) >= N*r_minus_g
  - sumR - sumB >= N*r_minus_b
  - N = WIN*WIN; differences are evaluated signed, so a negative difference fails.
REQ-026 A decision SHALL be held in a pending register and SHALL NOT be visible on zone_hit before the frame ends.
REQ-027 On the edge that accepts pixel (W-1,H-1), zone_hit SHALL load all pending decisions, result_valid SHALL pulse for the following cycle, and the FSM SHALL enter DONE.
REQ-028 pix_valid in IDLE or DONE SHALL be ignored.
REQ-029 frame_start while in ACTIVE SHALL pulse frame_err, leave zone_hit unchanged, and restart accumulation.
REQ-030 A zone that never completes its window SHALL report 0 in pending.
REQ-031 cfg_* changes in mid-frame SHALL have no effect until the next frame_start.

Reset
REQ-032 rst_n low SHALL asynchronously force:
  - state to IDLE
  - x, y, all sums, counts and pending to 0
  - zone_hit to 0, any_hit to 0, result_valid to 0, frame_err to 0
  - cfg registers to 10, 32, 16, 4, 4
REQ-033 Reset during a frame SHALL discard that frame; the next frame_start restarts normally.

Structure
REQ-034 Package color_det_pkg SHALL hold the rgb565_t struct, the cfg_t threshold struct with its reset constant, the state_t enum, and helper functions for zone centres and sum widths.
REQ-035 Sub-module zone_accum (one window: counters, sums, decision, pending) SHALL be instantiated NZ times by generate.

Verification
REQ-036 Default parameters and config; full frame of 0xF800 (R=31, G=0, B=0) -> zone_hit=9'h1FF, any_hit=1, result_valid one cycle after the last pixel.
REQ-037 Frame of 0x0000 except zone 4 window (x 158..162, y 118..122) = 0xF800 -> zone_hit=9'h010.
REQ-038 Full frame of 0x8410 (R=16, G=32, B=16) -> R-G/2 = 0 < 4 -> zone_hit=0. Repeat with cfg_r_minus_g=0, cfg_r_minus_b=0, cfg_g_max=32 -> zone_hit=9'h1FF.
REQ-039 frame_start after 1000 pixels of a red frame -> frame_err pulse, no result_valid, zone_hit holds its previous value; the next full red frame -> 9'h1FF.
REQ-040 rst_n low at pixel 40000 -> all outputs 0 immediately; extra pix_valid in DONE -> no change. With NX=4, NY=2, WIN=3 and random pix_valid gaps -> matches reference model.
